// File: rtl/uart_defines.sv
// Shared definitions for the UART byte packer: state encoding, word sizing and timeout default.
// The optional inter-byte timeout is enabled by UART_RX_PACK_TIMEOUT_EN.
package uart_defines;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_e;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1000;

    // LED-path word is half the nominal BYTE count in bits.
    function automatic int word_width(input int byte_cfg);
        return byte_cfg * 8 / 2;
    endfunction

    function automatic int bytes_per_word(input int byte_cfg);
        return (byte_cfg <= 2) ? 1 : byte_cfg / 2;
    endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// Inter-byte idle counter for the packer; flags expiry while a partial word is held.
// Only instantiated when UART_RX_PACK_TIMEOUT_EN is defined.
module uart_rx_timeout
    import uart_defines::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic active_i,
    input  logic accept_i,
    output logic expire_o
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q;

    // An accepted byte in the expiry cycle wins, so expiry is masked by accept.
    assign expire_o = active_i && !accept_i && (cnt_q == LIMIT);

    always_ff @(posedge clk) begin
        if (reset || !active_i || accept_i || expire_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/uart_rx_packer.sv
// Packs received UART bytes little-endian into W-bit words for the LED control stage.
// Define UART_RX_PACK_TIMEOUT_EN to drop partial words after TIMEOUT_CYCLES idle cycles.
module uart_rx_packer
    import uart_defines::*;
#(
    parameter  int BYTE           = 4,
    parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int W              = word_width(BYTE)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    input  logic         rx_error,
    output logic         write_valid,
    output logic [W-1:0] write_data,
    output logic         busy,
    output logic         err_drop,
    output logic         timeout_drop
);

    localparam int N  = bytes_per_word(BYTE);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (BYTE != 1 && BYTE != 2 && BYTE != 4 && BYTE != 8) begin : g_bad_byte
        $error("uart_rx_packer: BYTE must be 1, 2, 4 or 8");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("uart_rx_packer: TIMEOUT_CYCLES must be 2..65535");
    end

    state_e        state_q;
    logic [CW-1:0] count_q;
    logic [W-1:0]  shadow_q;
    logic [W-1:0]  write_data_q;
    logic          write_valid_q;
    logic          err_drop_q;
    logic          timeout_drop_q;

    logic          accept;
    logic          last_byte;
    logic          expire;
    logic [W+7:0]  merge;
    logic [W-1:0]  word_d;

    assign accept    = rx_valid && !rx_error;
    assign last_byte = (count_q == CW'(N - 1));

    // Extra top byte lets BYTE=1 drop rx_data[7:4] by plain truncation.
    always_comb begin
        merge = {8'h00, shadow_q};
        for (int k = 0; k < N; k++) begin
            if (count_q == CW'(k)) begin
                merge[8*k +: 8] = rx_data;
            end
        end
        word_d = merge[W-1:0];
    end

`ifdef UART_RX_PACK_TIMEOUT_EN
    uart_rx_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .active_i(state_q == ST_COLLECT),
        .accept_i(accept),
        .expire_o(expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            count_q        <= '0;
            shadow_q       <= '0;
            write_data_q   <= '0;
            write_valid_q  <= 1'b0;
            err_drop_q     <= 1'b0;
            timeout_drop_q <= 1'b0;
        end else begin
            write_valid_q  <= 1'b0;
            err_drop_q     <= 1'b0;
            timeout_drop_q <= 1'b0;
            if (state_q == ST_COLLECT && rx_error) begin
                err_drop_q <= 1'b1;
                state_q    <= ST_IDLE;
                count_q    <= '0;
                shadow_q   <= '0;
            end else if (accept) begin
                if (last_byte) begin
                    write_data_q  <= word_d;
                    write_valid_q <= 1'b1;
                    state_q       <= ST_IDLE;
                    count_q       <= '0;
                    shadow_q      <= '0;
                end else begin
                    shadow_q <= word_d;
                    count_q  <= count_q + 1'b1;
                    state_q  <= ST_COLLECT;
                end
            end else if (state_q == ST_COLLECT && expire) begin
                timeout_drop_q <= 1'b1;
                state_q        <= ST_IDLE;
                count_q        <= '0;
                shadow_q       <= '0;
            end
        end
    end

    assign write_valid  = write_valid_q;
    assign write_data   = write_data_q;
    assign busy         = (state_q == ST_COLLECT);
    assign err_drop     = err_drop_q;
    assign timeout_drop = timeout_drop_q;

endmodule

// File: tb/tb_uart_rx_packer.sv
// Directed bench for uart_rx_packer: three instances (BYTE=4/1/8) share one input stream.
// Timeout scenarios switch on UART_RX_PACK_TIMEOUT_EN.
module tb_uart_rx_packer;

    logic       clk;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_error;

    logic        u4_wv, u4_busy, u4_err, u4_to;
    logic [15:0] u4_wd;
    logic        u1_wv, u1_busy, u1_err, u1_to;
    logic [3:0]  u1_wd;
    logic        u8_wv, u8_busy, u8_err, u8_to;
    logic [31:0] u8_wd;

    int errors = 0;
    int checks = 0;
    int wv4_cnt = 0;
    int wv8_cnt = 0;
    logic [31:0] exp_q[$];

    uart_rx_packer #(.BYTE(4), .TIMEOUT_CYCLES(10)) u_dut4 (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_error(rx_error),
        .write_valid(u4_wv), .write_data(u4_wd), .busy(u4_busy), .err_drop(u4_err),
        .timeout_drop(u4_to)
    );

    uart_rx_packer #(.BYTE(1)) u_dut1 (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_error(rx_error),
        .write_valid(u1_wv), .write_data(u1_wd), .busy(u1_busy), .err_drop(u1_err),
        .timeout_drop(u1_to)
    );

    uart_rx_packer #(.BYTE(8)) u_dut8 (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_error(rx_error),
        .write_valid(u8_wv), .write_data(u8_wd), .busy(u8_busy), .err_drop(u8_err),
        .timeout_drop(u8_to)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; the DUT samples them on the next rising edge.
    task automatic drive(input logic v, input logic [7:0] d, input logic e);
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
        rx_error = e;
    endtask

    // Reset is held with a live byte on the bus to show it overrides inputs.
    task automatic rst();
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hEE;
        rx_error = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // scoreboard: every BYTE=4 word is matched against the expected queue
    always @(negedge clk) begin
        if (!reset && u4_wv) begin
            wv4_cnt++;
            if (exp_q.size() == 0) check("wv4_unexpected", 32'(u4_wv), 32'd0);
            else check("wd4_scoreboard", 32'(u4_wd), exp_q.pop_front());
        end
        if (!reset && u8_wv) wv8_cnt++;
    end

    initial begin
        int base4;
        int base8;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rx_error = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wv4", 32'(u4_wv), 0);
        check("rst_wd4", 32'(u4_wd), 0);
        check("rst_busy4", 32'(u4_busy), 0);
        check("rst_err4", 32'(u4_err), 0);
        check("rst_to4", 32'(u4_to), 0);
        check("rst_wd1", 32'(u1_wd), 0);
        check("rst_wd8", u8_wd, 0);
        check("rst_busy8", 32'(u8_busy), 0);
        reset = 1'b0;

        // two-byte word and BYTE=1 nibble path
        rst();
        exp_q.push_back(32'h1234);
        drive(1, 8'h34, 0);
        drive(1, 8'h12, 0);
        check("a_busy4", 32'(u4_busy), 1);
        check("a_wv4_early", 32'(u4_wv), 0);
        check("a_wv1", 32'(u1_wv), 1);
        check("a_wd1", 32'(u1_wd), 32'h4);
        drive(0, 8'h00, 0);
        check("a_wv4", 32'(u4_wv), 1);
        check("a_wd4", 32'(u4_wd), 32'h1234);
        check("a_busy4_done", 32'(u4_busy), 0);
        check("a_wd1_b", 32'(u1_wd), 32'h2);
        check("a_busy1", 32'(u1_busy), 0);
        drive(0, 8'h00, 0);
        check("a_wv4_pulse", 32'(u4_wv), 0);
        check("a_wd4_hold", 32'(u4_wd), 32'h1234);
        drive(1, 8'hA7, 0);
        drive(0, 8'h00, 0);
        check("a_wv1_a7", 32'(u1_wv), 1);
        check("a_wd1_a7", 32'(u1_wd), 32'h7);
        check("a_wd4_partial_hidden", 32'(u4_wd), 32'h1234);

        // error handling
        rst();
        drive(1, 8'h55, 0);
        drive(0, 8'h00, 1);
        check("b_busy4", 32'(u4_busy), 1);
        drive(0, 8'h00, 0);
        check("b_err4", 32'(u4_err), 1);
        check("b_busy4_after", 32'(u4_busy), 0);
        check("b_wv4", 32'(u4_wv), 0);
        check("b_err1_idle", 32'(u1_err), 0);
        drive(0, 8'h00, 1);
        drive(0, 8'h00, 0);
        check("b_err4_idle", 32'(u4_err), 0);
        drive(1, 8'hFF, 1);
        drive(0, 8'h00, 0);
        check("b_err_wins4", 32'(u4_busy), 0);
        check("b_err_wins1", 32'(u1_wv), 0);
        exp_q.push_back(32'h0201);
        drive(1, 8'h01, 0);
        drive(1, 8'h02, 0);
        drive(0, 8'h00, 0);
        check("b_wv4", 32'(u4_wv), 1);
        check("b_wd4", 32'(u4_wd), 32'h0201);

        // reset mid-word on BYTE=8
        rst();
        base8 = wv8_cnt;
        exp_q.push_back(32'h2211);
        drive(1, 8'h11, 0);
        drive(1, 8'h22, 0);
        drive(1, 8'h33, 0);
        drive(0, 8'h00, 0);
        check("c_busy8", 32'(u8_busy), 1);
        rst();
        check("c_busy8_rst", 32'(u8_busy), 0);
        check("c_err8_rst", 32'(u8_err), 0);
        check("c_wv8_rst", 32'(u8_wv), 0);
        exp_q.push_back(32'h5544);
        exp_q.push_back(32'h7766);
        drive(1, 8'h44, 0);
        drive(1, 8'h55, 0);
        drive(1, 8'h66, 0);
        drive(1, 8'h77, 0);
        drive(0, 8'h00, 0);
        check("c_wv8", 32'(u8_wv), 1);
        check("c_wd8", u8_wd, 32'h77665544);
        drive(0, 8'h00, 0);
        check("c_wv8_count", 32'(wv8_cnt - base8), 1);

        // back-to-back bytes
        rst();
        base4 = wv4_cnt;
        exp_q.push_back(32'h0201);
        exp_q.push_back(32'h0403);
        exp_q.push_back(32'h0605);
        exp_q.push_back(32'h0807);
        for (int i = 0; i < 8; i++) begin
            drive(1, 8'(i + 1), 0);
            if (i >= 1) check("d_wv4_alt", 32'(u4_wv), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        drive(0, 8'h00, 0);
        check("d_wv4_last", 32'(u4_wv), 1);
        check("d_wd4_last", 32'(u4_wd), 32'h0807);
        drive(0, 8'h00, 0);
        check("d_wv4_count", 32'(wv4_cnt - base4), 4);

`ifdef UART_RX_PACK_TIMEOUT_EN
        // expiry after ten idle cycles, then a byte landing exactly on expiry
        rst();
        drive(1, 8'hAA, 0);
        for (int k = 1; k <= 12; k++) begin
            drive(0, 8'h00, 0);
            if (k == 10) check("e_to4_before", 32'(u4_to), 0);
            if (k == 10) check("e_busy4_before", 32'(u4_busy), 1);
            if (k == 11) check("e_to4", 32'(u4_to), 1);
            if (k == 11) check("e_busy4_after", 32'(u4_busy), 0);
            if (k == 12) check("e_to4_pulse", 32'(u4_to), 0);
        end
        rst();
        exp_q.push_back(32'hBBAA);
        drive(1, 8'hAA, 0);
        repeat (9) drive(0, 8'h00, 0);
        drive(1, 8'hBB, 0);
        drive(0, 8'h00, 0);
        check("e_wv4_race", 32'(u4_wv), 1);
        check("e_wd4_race", 32'(u4_wd), 32'hBBAA);
        check("e_to4_race", 32'(u4_to), 0);
        drive(0, 8'h00, 0);
        check("e_to4_race_next", 32'(u4_to), 0);
`else
        // without the timeout a partial word is held indefinitely
        rst();
        exp_q.push_back(32'hBBAA);
        drive(1, 8'hAA, 0);
        repeat (15) drive(0, 8'h00, 0);
        check("e_busy4_hold", 32'(u4_busy), 1);
        check("e_to4_tied", 32'(u4_to), 0);
        drive(1, 8'hBB, 0);
        drive(0, 8'h00, 0);
        check("e_wv4_hold", 32'(u4_wv), 1);
        check("e_wd4_hold", 32'(u4_wd), 32'hBBAA);
`endif

        drive(0, 8'h00, 0);
        drive(0, 8'h00, 0);
        check("exp_q_empty", 32'(exp_q.size()), 0);
        check("to1_never", 32'(u1_to), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
